mii_tx: RTL
===========

# mii_tx

MII frame transmitter, the transmit counterpart of the `ethernet` receive path. It accepts payload bytes over a valid/ready byte stream and drives the PHY MII transmit pins. Each frame goes out as preamble, SFD, payload, zero padding up to the minimum length, a CRC-32 FCS, and then an enforced inter-frame gap. `clk` is the PHY transmit clock (one nibble per cycle); any crossing from the system clock domain happens in an upstream FIFO.

## Interface
- `MIN_PAYLOAD`, default 60: minimum bytes before the FCS; legal range 0..60; short frames are zero-padded.
- `MAX_PAYLOAD`, default 1514: payload bytes after which the frame is forcibly terminated.
- `IFG`, default 24: idle nibble cycles between frames (96 bit times).
- `clk` in 1: MII TX clock. All logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `tx_data` in 8: payload byte.
- `tx_valid` in 1: `tx_data` is valid.
- `tx_last` in 1: qualifies `tx_data` as the final byte of the frame.
- `tx_ready` out 1: byte is consumed on an edge where `tx_valid && tx_ready`.
- `tx_busy` out 1: high in every state except IDLE.
- `ethernet_tx_en` out 1: MII TX_EN.
- `ethernet_txd` out 4: MII TXD, low nibble of each byte first.
- `ethernet_tx_er` out 1: MII TX_ER; asserted only on an underrun.
- `underrun` out 1: one-cycle pulse when a frame is aborted.
- `frames_sent` out 16: count of completed frames; wraps 0xFFFF → 0x0000.

## Operation
- **Reset values.** All outputs are 0, the state is IDLE and the IFG counter is 0, so a frame may start immediately after reset.
- **Reset mid-frame.** The pins drop to 0 asynchronously and nothing is counted.
- **Payload counter.** `byte_cnt` is 11 bits, cleared in IDLE, and incremented on each accepted byte and on each pad byte.
- **CRC.** IEEE 802.3 reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF, updated once per nibble over payload and pad nibbles only. The FCS is the complement of the final CRC, sent as `crc[3:0]` first through `crc[31:28]` last.
- **IDLE.** `tx_en` = 0 and `tx_ready` = 0. When `tx_valid` = 1 and the IFG has expired, go to PREAMBLE. The byte is not consumed here.
- **PREAMBLE.** 15 cycles with `txd` = 0x5 and `tx_en` = 1, then go to SFD.
- **SFD.** One cycle with `txd` = 0xD and `tx_ready` = 1.
  - Byte accepted: latch it into the holding register and go to DATA_LO.
  - `tx_valid` = 0: go to ABORT.
- **DATA_LO.** Drive `hold[3:0]`, then go to DATA_HI.
- **DATA_HI.** Drive `hold[7:4]`. Choose the next state in this priority order:
  1. Held byte had `tx_last`, or `byte_cnt` = `MAX_PAYLOAD`: go to PAD if `byte_cnt` < `MIN_PAYLOAD`, otherwise FCS. `tx_ready` = 0.
  2. Otherwise `tx_ready` = 1. Byte accepted: go to DATA_LO. `tx_valid` = 0: go to ABORT.
- **Oversize frame.** If `MAX_PAYLOAD` is reached without `tx_last`, the FCS is sent normally. The block then enters DISCARD instead of IFG.
- **DISCARD.** `tx_en` = 0 and `tx_ready` = 1; bytes are dropped until one with `tx_last` is accepted, then go to IFG.
- **PAD.** Nibbles of 0x0, two per byte, until `byte_cnt` = `MIN_PAYLOAD`, then go to FCS.
- **FCS.** 8 nibbles. After the last one, increment `frames_sent` and go to IFG.
- **ABORT.** One cycle with `tx_en` = 1, `tx_er` = 1, `txd` = 0x0, and `underrun` pulsed. Then go to DISCARD if the last byte has not yet been seen, otherwise IFG.
- **IFG.** `tx_en` = 0 for `IFG` cycles, then go to IDLE.

## Timing
- **Start latency.** `tx_valid` rising in IDLE with the gap satisfied gives `tx_en` = 1 on the next cycle.
- **First-byte acceptance.** The first byte is accepted at cycle 16 of `tx_en` (the SFD cycle). Later bytes are accepted every second cycle, on DATA_HI.
- **Frame length.** A frame with N payload bytes holds `tx_en` high for exactly 16 + 2·max(N, `MIN_PAYLOAD`) + 8 cycles, contiguously.
- **Back-to-back frames.** Consecutive frames are separated by at least `IFG` cycles with `tx_en` = 0.
- **Last byte and padding.** `tx_last` seen on a byte with `byte_cnt` already ≥ `MIN_PAYLOAD` gives no padding.
- **Minimum payload 0.** With `MIN_PAYLOAD` = 0, a 1-byte frame is legal.
- **Counter wrap.** `frames_sent` reaching 0xFFFF wraps to 0 on the next completed frame.

## Test plan
- **FCS check.** `MIN_PAYLOAD` = 0; stream ASCII "123456789" with `tx_last` on '9'.
  - Expect 15×0x5, then 0xD, then data nibbles 1,3,2,3,…,9,3.
  - Then FCS nibbles 6,2,9,3,4,F,B,C.
  - `frames_sent` = 1.
- **Padding.** Default parameters; send 1 byte 0xAB.
  - Expect nibbles B,A followed by 118 zero nibbles, then 8 FCS nibbles.
  - `tx_en` high for exactly 144 cycles.
- **Inter-frame gap.** Hold `tx_valid` = 1 continuously across two 64-byte frames.
  - Expect exactly 24 cycles with `tx_en` = 0 between them; `tx_ready` duty is 1 in 2 during DATA.
- **Underrun.** Drop `tx_valid` after the 10th byte.
  - Expect one cycle of `tx_er` = 1 with `tx_en` = 1, and `underrun` pulsed.
  - Remaining bytes up to `tx_last` are consumed with no PHY activity; `frames_sent` is unchanged.
- **Oversize.** `MAX_PAYLOAD` = 64; send 80 bytes.
  - Expect 64 bytes, then FCS, then `tx_en` low.
  - Bytes 65–80 are consumed with `tx_ready` = 1; the next frame starts only after the gap.
- **Reset mid-frame.** Assert `reset` during FCS.
  - `tx_en`, `txd` and `tx_ready` go to 0 immediately; `frames_sent` = 0.
  - A new frame starts 1 cycle after release when `tx_valid` = 1.

Source files
------------

// File: rtl/mii_tx.sv
// mii_tx: MII frame transmitter (preamble, SFD, payload, zero pad, CRC-32 FCS, inter-frame gap)
module mii_tx #(
  parameter int MIN_PAYLOAD = 60,
  parameter int MAX_PAYLOAD = 1514,
  parameter int IFG = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  input  logic        tx_last,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        ethernet_tx_en,
  output logic [3:0]  ethernet_txd,
  output logic        ethernet_tx_er,
  output logic        underrun,
  output logic [15:0] frames_sent
);
  typedef enum logic [3:0] {IDLE, PREAMBLE, SFD, DATA_LO, DATA_HI, PAD, FCS, ABORT, DISCARD, GAP} state_t;
  state_t      state;
  logic [7:0]  hold;
  logic        hold_last, oversize, end_frame;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic [3:0]  ncnt;
  logic [15:0] ifg_cnt;
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'd0, d};
    for (int i = 0; i < 4; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  // Pin outputs decode registered state only, so reset clears them asynchronously.
  always_comb begin
    end_frame = hold_last || byte_cnt == 11'(MAX_PAYLOAD);
    tx_busy = state != IDLE;
    ethernet_tx_en = state inside {PREAMBLE, SFD, DATA_LO, DATA_HI, PAD, FCS, ABORT};
    ethernet_tx_er = state == ABORT;
    underrun = state == ABORT;
    ethernet_txd = state == PREAMBLE ? 4'h5 :
                   state == SFD      ? 4'hD :
                   state == DATA_LO  ? hold[3:0] :
                   state == DATA_HI  ? hold[7:4] :
                   state == FCS      ? ~crc[3:0] : 4'h0;
    tx_ready = state inside {SFD, DISCARD} || (state == DATA_HI && !end_frame);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      hold <= '0;
      hold_last <= 1'b0;
      oversize <= 1'b0;
      byte_cnt <= '0;
      crc <= '1;
      ncnt <= '0;
      ifg_cnt <= '0;
      frames_sent <= '0;
    end else
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          hold_last <= 1'b0;
          oversize <= 1'b0;
          crc <= '1;
          ncnt <= 4'd14;
          if (tx_valid) state <= PREAMBLE;
        end
        PREAMBLE: begin
          ncnt <= ncnt - 4'd1;
          if (ncnt == 4'd0) state <= SFD;
        end
        SFD:
          if (tx_valid) begin
            hold <= tx_data;
            hold_last <= tx_last;
            byte_cnt <= byte_cnt + 11'd1;
            state <= DATA_LO;
          end else state <= ABORT;
        DATA_LO: begin
          crc <= crc_nib(crc, hold[3:0]);
          state <= DATA_HI;
        end
        DATA_HI: begin
          crc <= crc_nib(crc, hold[7:4]);
          if (end_frame) begin
            oversize <= !hold_last;
            ncnt <= byte_cnt < 11'(MIN_PAYLOAD) ? 4'd0 : 4'd7;
            state <= byte_cnt < 11'(MIN_PAYLOAD) ? PAD : FCS;
          end else if (tx_valid) begin
            hold <= tx_data;
            hold_last <= tx_last;
            byte_cnt <= byte_cnt + 11'd1;
            state <= DATA_LO;
          end else state <= ABORT;
        end
        PAD: begin
          crc <= crc_nib(crc, 4'h0);
          ncnt <= ncnt + 4'd1;
          if (ncnt[0]) begin
            byte_cnt <= byte_cnt + 11'd1;
            if (byte_cnt + 11'd1 == 11'(MIN_PAYLOAD)) begin
              ncnt <= 4'd7;
              state <= FCS;
            end
          end
        end
        FCS: begin
          crc <= {4'h0, crc[31:4]};
          ncnt <= ncnt - 4'd1;
          if (ncnt == 4'd0) begin
            frames_sent <= frames_sent + 16'd1;
            ifg_cnt <= 16'(IFG - 1);
            state <= oversize ? DISCARD : GAP;
          end
        end
        ABORT: begin
          ifg_cnt <= 16'(IFG - 1);
          state <= hold_last ? GAP : DISCARD;
        end
        DISCARD:
          if (tx_valid && tx_last) begin
            ifg_cnt <= 16'(IFG - 1);
            state <= GAP;
          end
        // The single IDLE cycle completes the gap, so GAP lasts IFG-1 cycles.
        GAP: begin
          ifg_cnt <= ifg_cnt - 16'd1;
          if (ifg_cnt <= 16'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
